// File: rtl/dmem_defs_pkg.sv
// Shared definitions for the data-memory responder.
//   - funct3 size encodings used on the load/store port
//   - responder FSM state encoding
//   - RAM depth in 32-bit words
package dmem_defs;

    localparam int unsigned DMEM_WORDS = 64;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp,
        StErr
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data-memory responder.
// Ports:
//   we       in   1 = store, 0 = load
//   size     in   funct3 access size
//   addr_lo  in   byte offset within the word
//   wdata    in   raw store data (bytes taken from the low end)
//   rdword   in   32-bit word currently held at the target address
//   be       out  store byte enables (all zero when the access is bad)
//   wdata_al out  store data replicated onto every candidate lane
//   ldata    out  selected and extended load data
//   bad      out  illegal size for the direction, or misaligned
module dmem_lane_align
    import dmem_defs::*;
(
    input  logic        we,
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdword,
    output logic [3:0]  be,
    output logic [31:0] wdata_al,
    output logic [31:0] ldata,
    output logic        bad
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdword[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdword[31:16] : rdword[15:0];
    end

    always_comb begin
        be       = 4'b0000;
        wdata_al = 32'h0;
        ldata    = 32'h0;
        bad      = 1'b0;
        case (size)
            SZ_B: begin
                be       = 4'b0001 << addr_lo;
                wdata_al = {4{wdata[7:0]}};
                ldata    = {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_BU: begin
                bad   = we;
                ldata = {24'h0, byte_sel};
            end
            SZ_H: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{wdata[15:0]}};
                ldata    = {{16{half_sel[15]}}, half_sel};
                bad      = addr_lo[0];
            end
            SZ_HU: begin
                ldata = {16'h0, half_sel};
                bad   = we | addr_lo[0];
            end
            SZ_W: begin
                be       = 4'b1111;
                wdata_al = wdata;
                ldata    = rdword;
                bad      = (addr_lo != 2'b00);
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            be = 4'b0000;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: 256-byte little-endian RAM behind a req/ready port
// with WAIT_CYCLES programmable wait states.
// Optional feature macro: DMEM_MMIO_EN maps word MMIO_ADDR[7:2] onto mmio_out.
// Ports:
//   clk      in   clock
//   rest     in   synchronous active-high reset
//   req      in   access request, held until ready
//   we       in   1 = store, 0 = load
//   size     in   funct3 size (B/H/W/BU/HU)
//   addr     in   byte address
//   wdata    in   store data
//   rdata    out  registered load result
//   ready    out  one-cycle completion pulse
//   err      out  qualifies ready: misaligned or illegal access
//   mmio_out out  output register (DMEM_MMIO_EN builds only)
module dmem_responder
    import dmem_defs::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [7:0]  MMIO_ADDR   = 8'hFC
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  size,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
`ifdef DMEM_MMIO_EN
    ,
    output logic [31:0] mmio_out
`endif
);

`ifdef DMEM_MMIO_EN
    localparam bit MmioEn = 1'b1;
`else
    localparam bit MmioEn = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [2:0]  size_q;
    logic [7:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        commit;

    logic [31:0] mem [DMEM_WORDS];

    // In IDLE the live request is decoded so a zero-wait access can commit
    // on its acceptance edge; later states use the latched copy.
    logic        cur_we;
    logic [2:0]  cur_size;
    logic [7:0]  cur_addr;
    logic [31:0] cur_wdata;
    logic        is_mmio;
    logic [31:0] rdword;
    logic [3:0]  be;
    logic [31:0] wdata_al;
    logic [31:0] ldata;
    logic        bad;

    always_comb begin
        if (state_q == StIdle) begin
            cur_we    = we;
            cur_size  = size;
            cur_addr  = addr;
            cur_wdata = wdata;
        end else begin
            cur_we    = we_q;
            cur_size  = size_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
        is_mmio = MmioEn && (cur_addr[7:2] == MMIO_ADDR[7:2]);
    end

`ifdef DMEM_MMIO_EN
    logic [31:0] mmio_q;
    assign rdword   = is_mmio ? mmio_q : mem[cur_addr[7:2]];
    assign mmio_out = mmio_q;

    always_ff @(posedge clk) begin
        if (rest) begin
            mmio_q <= 32'h0;
        end else if (commit && cur_we && is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mmio_q[8*i +: 8] <= wdata_al[8*i +: 8];
            end
        end
    end
`else
    assign rdword = mem[cur_addr[7:2]];
`endif

    dmem_lane_align u_align (
        .we      (cur_we),
        .size    (cur_size),
        .addr_lo (cur_addr[1:0]),
        .wdata   (cur_wdata),
        .rdword  (rdword),
        .be      (be),
        .wdata_al(wdata_al),
        .ldata   (ldata),
        .bad     (bad)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        ready   = 1'b0;
        err     = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    if (bad) begin
                        state_d = StErr;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            StWait: begin
                if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                ready   = 1'b1;
                state_d = StIdle;
            end
            StErr: begin
                ready   = 1'b1;
                err     = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 3'b000;
            addr_q  <= 8'h00;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && req) begin
                we_q    <= we;
                size_q  <= size;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (commit && !cur_we) begin
                rdata_q <= ldata;
            end
        end
    end

    // RAM is not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (commit && cur_we && !is_mmio && !rest) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[cur_addr[7:2]][8*i +: 8] <= wdata_al[8*i +: 8];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    logic        clk = 1'b0;
    logic        rest = 1'b1;
    logic        req = 1'b0, we = 1'b0;
    logic [2:0]  size = 3'b000;
    logic [7:0]  addr = 8'h00;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        ready, err;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [2:0]  size0 = 3'b010;
    logic [7:0]  addr0 = 8'h00;
    logic [31:0] wdata0 = 32'h0;
    logic [31:0] rdata0;
    logic        ready0, err0;
`ifdef DMEM_MMIO_EN
    logic [31:0] mmio_out, mmio_out0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_responder #(.WAIT_CYCLES(1), .MMIO_ADDR(8'hFC)) u_dut (
        .clk(clk), .rest(rest), .req(req), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ready(ready), .err(err)
`ifdef DMEM_MMIO_EN
        , .mmio_out(mmio_out)
`endif
    );

    dmem_responder #(.WAIT_CYCLES(0), .MMIO_ADDR(8'hFC)) u_dut0 (
        .clk(clk), .rest(rest), .req(req0), .we(we0), .size(size0), .addr(addr0),
        .wdata(wdata0), .rdata(rdata0), .ready(ready0), .err(err0)
`ifdef DMEM_MMIO_EN
        , .mmio_out(mmio_out0)
`endif
    );

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction on the WAIT_CYCLES=1 instance; ready expected in cycle
    // A+2 for good accesses and A+1 for error responses.
    task automatic do_txn(input string name, input logic w, input logic [2:0] sz,
                          input logic [7:0] a, input logic [31:0] wd,
                          input logic e_err, input logic [31:0] e_rd, input bit pulse);
        int cyc;
        bit seen;
        @(negedge clk);
        req = 1'b1; we = w; size = sz; addr = a; wdata = wd;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (pulse) req = 1'b0;
            if (ready) seen = 1;
        end
        req = 1'b0;
        chk({name, " latency"}, 32'(cyc), e_err ? 32'd1 : 32'd2);
        chk({name, " err"}, {31'h0, err}, {31'h0, e_err});
        chk({name, " rdata"}, rdata, e_rd);
        @(negedge clk);
        chk({name, " ready/err after"}, {30'h0, ready, err}, 32'h0);
    endtask

    initial begin
        vecs.push_back('{1'b1, W,     8'h10, 32'hDEADBEEF, 1'b0, 32'h00000000});
        vecs.push_back('{1'b0, W,     8'h10, 32'h0,        1'b0, 32'hDEADBEEF});
        vecs.push_back('{1'b1, B,     8'h13, 32'h00000080, 1'b0, 32'hDEADBEEF});
        vecs.push_back('{1'b0, B,     8'h13, 32'h0,        1'b0, 32'hFFFFFF80});
        vecs.push_back('{1'b0, BU,    8'h13, 32'h0,        1'b0, 32'h00000080});
        vecs.push_back('{1'b0, W,     8'h10, 32'h0,        1'b0, 32'h80ADBEEF});
        vecs.push_back('{1'b0, H,     8'h11, 32'h0,        1'b1, 32'h80ADBEEF});
        vecs.push_back('{1'b0, 3'b011, 8'h10, 32'h0,       1'b1, 32'h80ADBEEF});
        vecs.push_back('{1'b0, W,     8'h10, 32'h0,        1'b0, 32'h80ADBEEF});
        vecs.push_back('{1'b1, H,     8'h12, 32'h0000A5B6, 1'b0, 32'h80ADBEEF});
        vecs.push_back('{1'b0, H,     8'h12, 32'h0,        1'b0, 32'hFFFFA5B6});
        vecs.push_back('{1'b0, HU,    8'h12, 32'h0,        1'b0, 32'h0000A5B6});
        vecs.push_back('{1'b0, B,     8'h10, 32'h0,        1'b0, 32'hFFFFFFEF});
        vecs.push_back('{1'b0, H,     8'h10, 32'h0,        1'b0, 32'hFFFFBEEF});
        vecs.push_back('{1'b1, BU,    8'h10, 32'h55555555, 1'b1, 32'hFFFFBEEF});
        vecs.push_back('{1'b1, W,     8'h22, 32'h66666666, 1'b1, 32'hFFFFBEEF});
        vecs.push_back('{1'b0, W,     8'h10, 32'h0,        1'b0, 32'hA5B6BEEF});
        vecs.push_back('{1'b1, W,     8'h20, 32'h11111111, 1'b0, 32'hA5B6BEEF});
        vecs.push_back('{1'b1, W,     8'hFC, 32'h0000005A, 1'b0, 32'hA5B6BEEF});
        vecs.push_back('{1'b0, W,     8'hFC, 32'h0,        1'b0, 32'h0000005A});

        repeat (2) @(negedge clk);
        rest = 1'b0;
        chk("reset ready/err", {30'h0, ready, err}, 32'h0);
        chk("reset rdata", rdata, 32'h0);
        chk("reset rdata0", rdata0, 32'h0);
`ifdef DMEM_MMIO_EN
        chk("reset mmio_out", mmio_out, 32'h0);
`endif

        foreach (vecs[i]) begin
            do_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rdata, 1'b0);
        end
`ifdef DMEM_MMIO_EN
        chk("mmio_out after SW", mmio_out, 32'h0000005A);
`endif

        // Reset during WAIT abandons the store.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = W; addr = 8'h20; wdata = 32'h12345678;
        @(negedge clk);
        chk("abort wait ready", {31'h0, ready}, 32'h0);
        rest = 1'b1;
        req = 1'b0;
        @(negedge clk);
        rest = 1'b0;
        chk("abort ready/err", {30'h0, ready, err}, 32'h0);
        chk("abort rdata", rdata, 32'h0);
`ifdef DMEM_MMIO_EN
        chk("abort mmio_out", mmio_out, 32'h0);
`endif
        do_txn("abort readback", 1'b0, W, 8'h20, 32'h0, 1'b0, 32'h11111111, 1'b0);

        // Dropping req after acceptance still completes the store.
        do_txn("pulsed SB", 1'b1, B, 8'h21, 32'h00000033, 1'b0, 32'h11111111, 1'b1);
        do_txn("pulsed readback", 1'b0, W, 8'h20, 32'h0, 1'b0, 32'h11113311, 1'b0);

        // Zero-wait instance, req held high: ready on every second cycle.
        begin
            logic        ops_we[4]    = '{1'b1, 1'b1, 1'b0, 1'b0};
            logic [7:0]  ops_addr[4]  = '{8'h00, 8'h04, 8'h00, 8'h04};
            logic [31:0] ops_wdata[4] = '{32'hAAAA0000, 32'h0000BBBB, 32'h0, 32'h0};
            logic [31:0] ops_exp[4]   = '{32'h0, 32'h0, 32'hAAAA0000, 32'h0000BBBB};
            @(negedge clk);
            req0 = 1'b1; size0 = W;
            we0 = ops_we[0]; addr0 = ops_addr[0]; wdata0 = ops_wdata[0];
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk($sformatf("b2b%0d ready", k), {30'h0, ready0, err0}, 32'h2);
                chk($sformatf("b2b%0d rdata", k), rdata0, ops_exp[k]);
                if (k < 3) begin
                    we0 = ops_we[k+1]; addr0 = ops_addr[k+1]; wdata0 = ops_wdata[k+1];
                end else begin
                    req0 = 1'b0;
                end
                @(negedge clk);
                chk($sformatf("b2b%0d gap", k), {31'h0, ready0}, 32'h0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
